// File: rtl/ntt_pkg.sv
// ntt_pkg: shared NTT datapath widths and modular multiplier latency
package ntt_pkg;
  localparam int COEF_W = 28;
  localparam int MODMUL_LAT = 4;
  typedef logic [COEF_W-1:0] coef_t;
  typedef logic [2*COEF_W-1:0] wide_t;
endpackage

// File: rtl/mod_mul_barrett_if.sv
// mod_mul_barrett_if: operand/result valid-ready channel with sideband tag
interface mod_mul_barrett_if import ntt_pkg::*; #(
  parameter int W = COEF_W,
  parameter int TAG_W = 10
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, out;
  logic [TAG_W-1:0] in_tag, out_tag;
  modport master(output in_valid, a, b, in_tag, out_ready, input in_ready, out_valid, out, out_tag);
  modport slave(input in_valid, a, b, in_tag, out_ready, output in_ready, out_valid, out, out_tag);
endinterface

// File: rtl/mod_mul_barrett_mod_corr.sv
// mod_corr: reduces r < 3q into [0, q) with two conditional subtractions
module mod_corr #(
  parameter int W = 28
) (
  input  logic [W+1:0] r,
  input  logic [W-1:0] q,
  output logic [W-1:0] y
);
  logic [W+1:0] q1, q2;
  assign q1 = {2'b00, q};
  assign q2 = {1'b0, q, 1'b0};
  // the difference fits in W bits, so subtract on the low W bits only
  always_comb y = r >= q2 ? r[W-1:0] - {q[W-2:0], 1'b0} : r >= q1 ? r[W-1:0] - q : r[W-1:0];
endmodule

// File: rtl/mod_mul_barrett.sv
// mod_mul_barrett: 4-stage pipelined (a*b) mod q using Barrett reduction
module mod_mul_barrett import ntt_pkg::*; #(
  parameter int W = COEF_W,
  parameter int TAG_W = 10,
  parameter int MU_W = W + 1
) (
  input logic clk,
  input logic rst_n,
  input logic [W-1:0] q,
  input logic [MU_W-1:0] mu,
  mod_mul_barrett_if.slave bus
);
  logic adv;
  logic v1, v2, v3, v4;
  logic [TAG_W-1:0] tag1, tag2, tag3, tag4;
  logic [2*W-1:0] x1, x_n;
  logic [W:0] t2, t_n;
  logic [W+1:0] xl2, r3, r_n;
  logic [W-1:0] y4, y_n;
  assign adv = !v4 || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = v4;
  assign bus.out = y4;
  assign bus.out_tag = tag4;
  assign x_n = {{W{1'b0}}, bus.a} * {{W{1'b0}}, bus.b};
  assign t_n = (W+1)'(({{MU_W{1'b0}}, x1[2*W-1:W-1]} * {{(W+1){1'b0}}, mu}) >> (W+1));
  assign r_n = xl2 - {1'b0, t2} * {2'b00, q};
  mod_corr #(.W(W)) u_corr (.r(r3), .q(q), .y(y_n));
  // whole pipeline advances or holds together; bubbles travel as invalid slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1, v2, v3, v4} <= '0;
      {tag1, tag2, tag3, tag4} <= '0;
      x1 <= '0;
      t2 <= '0;
      xl2 <= '0;
      r3 <= '0;
      y4 <= '0;
    end else if (adv) begin
      v1 <= bus.in_valid;
      tag1 <= bus.in_tag;
      x1 <= x_n;
      v2 <= v1;
      tag2 <= tag1;
      t2 <= t_n;
      xl2 <= x1[W+1:0];
      v3 <= v2;
      tag3 <= tag2;
      r3 <= r_n;
      v4 <= v3;
      tag4 <= tag3;
      y4 <= y_n;
    end
  end
endmodule

// File: tb/tb_mod_mul_barrett.sv
// tb_mod_mul_barrett: randomized self-checking bench against a (a*b)%q model
module tb_mod_mul_barrett;
  import ntt_pkg::*;
  localparam int W = COEF_W;
  localparam int TAG_W = 10;
  typedef struct {
    logic [W-1:0] v;
    logic [TAG_W-1:0] tag;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [W-1:0] q;
  logic [W:0] mu;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  exp_t exp_q[$];
  mod_mul_barrett_if #(.W(W), .TAG_W(TAG_W)) bus();
  mod_mul_barrett #(.W(W), .TAG_W(TAG_W), .MU_W(W + 1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .q(q),
    .mu(mu),
    .bus(bus)
  );
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    return W'((64'(x) * 64'(y)) % 64'(q));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    vectors++;
    if (bus.out !== '0) begin miscompares++; $display("FAIL reset_out got=%0d exp=0", bus.out); end
    vectors++;
    if (bus.out_tag !== '0) begin miscompares++; $display("FAIL reset_out_tag got=%0d exp=0", bus.out_tag); end
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    step();
    step();
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_known();
    logic [W-1:0] va[5], vb[5], ve[5];
    logic [TAG_W-1:0] vt[5];
    int lat;
    va = '{W'(0), W'(1), q - 1, W'(2), {W{1'b1}}};
    vb = '{W'(123456), q - 1, q - 1, (q + 1) / 2, {W{1'b1}}};
    ve = '{W'(0), q - 1, W'(1), W'(1), W'(786420)};
    vt = '{TAG_W'(5), TAG_W'(6), TAG_W'(7), TAG_W'(8), TAG_W'(9)};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a = va[i];
      bus.b = vb[i];
      bus.in_tag = vt[i];
      step();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin step(); lat++; end
      vectors++;
      if (lat != MODMUL_LAT) begin miscompares++; $display("FAIL known_latency[%0d] got=%0d exp=%0d", i, lat, MODMUL_LAT); end
      vectors++;
      if (bus.out !== ve[i]) begin miscompares++; $display("FAIL known_out[%0d] got=%0d exp=%0d", i, bus.out, ve[i]); end
      vectors++;
      if (bus.out_tag !== vt[i]) begin miscompares++; $display("FAIL known_tag[%0d] got=%0d exp=%0d", i, bus.out_tag, vt[i]); end
      step();
    end
  endtask

  task automatic test_back_to_back(input int n);
    int sent, got, guard;
    exp_t e;
    sent = 0;
    got = 0;
    guard = 0;
    exp_q.delete();
    while (got < n && guard < n + 50) begin
      bus.out_ready = 1'b1;
      bus.in_valid = sent < n;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.in_tag = TAG_W'(sent);
      #1;
      if (bus.in_valid && bus.in_ready) begin exp_q.push_back('{model(bus.a, bus.b), bus.in_tag, cyc}); sent++; end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL b2b_spurious got=%0d exp=none", bus.out); end
        else begin
          e = exp_q.pop_front();
          got++;
          if (bus.out !== e.v || bus.out_tag !== e.tag || cyc - e.cyc != MODMUL_LAT)
            begin miscompares++; $display("FAIL b2b_result got=%0d/%0d/lat%0d exp=%0d/%0d/lat%0d", bus.out, bus.out_tag, cyc - e.cyc, e.v, e.tag, MODMUL_LAT); end
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      guard++;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (got != n) begin miscompares++; $display("FAIL b2b_count got=%0d exp=%0d", got, n); end
  endtask

  task automatic test_stall();
    int cur, got, guard;
    exp_t e;
    cur = 0;
    exp_q.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = cur < 6;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.in_tag = TAG_W'(cur);
      #1;
      vectors++;
      if (bus.in_ready !== !bus.out_valid) begin miscompares++; $display("FAIL stall_in_ready[%0d] got=%0b exp=%0b", i, bus.in_ready, !bus.out_valid); end
      if (bus.out_valid) begin
        vectors++;
        if (bus.out_tag !== '0) begin miscompares++; $display("FAIL stall_held_tag[%0d] got=%0d exp=0", i, bus.out_tag); end
      end
      if (bus.in_valid && bus.in_ready) begin exp_q.push_back('{model(bus.a, bus.b), bus.in_tag, cyc}); cur++; end
      step();
    end
    vectors++;
    if (cur != 4) begin miscompares++; $display("FAIL stall_accepted got=%0d exp=4", cur); end
    got = 0;
    guard = 0;
    while (got < 6 && guard < 40) begin
      bus.out_ready = 1'b1;
      bus.in_valid = cur < 6;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.in_tag = TAG_W'(cur);
      #1;
      if (bus.in_valid && bus.in_ready) begin exp_q.push_back('{model(bus.a, bus.b), bus.in_tag, cyc}); cur++; end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL stall_spurious got=%0d exp=none", bus.out_tag); end
        else begin
          e = exp_q.pop_front();
          if (bus.out !== e.v || bus.out_tag !== e.tag || bus.out_tag !== TAG_W'(got))
            begin miscompares++; $display("FAIL stall_drain got=%0d/%0d exp=%0d/%0d", bus.out, bus.out_tag, e.v, got); end
          got++;
        end
      end
      step();
      guard++;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (got != 6) begin miscompares++; $display("FAIL stall_drain_count got=%0d exp=6", got); end
  endtask

  task automatic test_async_reset();
    int lat;
    logic [W-1:0] ea, eb;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.in_tag = TAG_W'(256 + i);
      step();
    end
    bus.in_valid = 1'b0;
    #2;
    vectors++;
    if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL arst_pre_valid got=%0b exp=1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_out_valid got=%0b exp=0", bus.out_valid); end
    vectors++;
    if (bus.out !== '0) begin miscompares++; $display("FAIL arst_out got=%0d exp=0", bus.out); end
    vectors++;
    if (bus.out_tag !== '0) begin miscompares++; $display("FAIL arst_out_tag got=%0d exp=0", bus.out_tag); end
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_in_ready got=%0b exp=1", bus.in_ready); end
    step();
    step();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_stale[%0d] got=%0b exp=0", i, bus.out_valid); end
    end
    ea = W'($urandom);
    eb = W'($urandom);
    bus.in_valid = 1'b1;
    bus.a = ea;
    bus.b = eb;
    bus.in_tag = TAG_W'(77);
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin step(); lat++; end
    vectors++;
    if (lat != MODMUL_LAT || bus.out !== model(ea, eb) || bus.out_tag !== TAG_W'(77))
      begin miscompares++; $display("FAIL arst_first got=%0d/%0d/lat%0d exp=%0d/77/lat%0d", bus.out, bus.out_tag, lat, model(ea, eb), MODMUL_LAT); end
    step();
  endtask

  task automatic test_random_stall(input int n);
    int sent, got, guard;
    logic hold;
    logic [W-1:0] h_out;
    logic [TAG_W-1:0] h_tag;
    exp_t e;
    sent = 0;
    got = 0;
    guard = 0;
    hold = 1'b0;
    h_out = '0;
    h_tag = '0;
    exp_q.delete();
    while (got < n && guard < 20 * n) begin
      if (hold) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out !== h_out || bus.out_tag !== h_tag)
          begin miscompares++; $display("FAIL rnd_hold got=%0b/%0d/%0d exp=1/%0d/%0d", bus.out_valid, bus.out, bus.out_tag, h_out, h_tag); end
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid = sent < n;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.in_tag = TAG_W'(sent);
      #1;
      hold = bus.out_valid && !bus.out_ready;
      h_out = bus.out;
      h_tag = bus.out_tag;
      if (bus.in_valid && bus.in_ready) begin exp_q.push_back('{model(bus.a, bus.b), bus.in_tag, cyc}); sent++; end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL rnd_spurious got=%0d exp=none", bus.out_tag); end
        else begin
          e = exp_q.pop_front();
          got++;
          if (bus.out !== e.v || bus.out_tag !== e.tag)
            begin miscompares++; $display("FAIL rnd_result got=%0d/%0d exp=%0d/%0d", bus.out, bus.out_tag, e.v, e.tag); end
        end
      end
      step();
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    vectors++;
    if (got != n || exp_q.size() != 0) begin miscompares++; $display("FAIL rnd_count got=%0d/%0d exp=%0d/0", got, exp_q.size(), n); end
  endtask

  initial begin
    q = W'(268369921);
    mu = (W+1)'((64'd1 << (2 * W)) / 64'(q));
    test_reset();
    test_known();
    test_back_to_back(10000);
    test_stall();
    test_async_reset();
    test_random_stall(1000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
